// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output stage: default sample width and the
// run-state encoding.
package pwm_pkg;

  localparam int PWM_WIDTH = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running tick generator: one tick every PRESCALE clocks, held at zero
// while cleared so the first period after start is full length.
module pwm_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign o_tick = !i_clear && (count == LAST);

endmodule

// File: rtl/pwm_output_stage.sv
// PWM output stage: double-buffered duty sample, period counter, registered
// pin drive, with graceful stop at the end of the current period.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int WIDTH    = PWM_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_sample,
  input  logic             i_sample_valid,
  output logic             o_sample_ready,
  output logic             o_pwm,
  output logic             o_period_start,
  output logic             o_underrun
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  pwm_state_t       state;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] shadow;
  logic             shadow_full;
  logic             tick;
  logic             prescale_clear;
  logic             transfer;
  logic             boundary;

  assign prescale_clear = (state == ST_IDLE);

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (prescale_clear),
    .o_tick  (tick)
  );

  // NOTE: a default before the case keeps every path assigned, so no latch.
  always_comb begin
    o_sample_ready = 1'b0;
    case (state)
      ST_IDLE: o_sample_ready = 1'b1;
      ST_RUN:  o_sample_ready = !shadow_full;
      default: o_sample_ready = 1'b0;
    endcase
  end

  assign transfer = i_sample_valid && o_sample_ready;
  assign boundary = tick && (counter == CNT_MAX);

  // NOTE: the sample registers are small and are reset along with the
  // control state, so a reset never exposes a stale duty value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      counter        <= '0;
      active         <= '0;
      shadow         <= '0;
      shadow_full    <= 1'b0;
      o_pwm          <= 1'b0;
      o_period_start <= 1'b0;
      o_underrun     <= 1'b0;
    end else begin
      o_period_start <= 1'b0;
      o_underrun     <= 1'b0;
      o_pwm          <= (state != ST_IDLE) && (counter < active);

      case (state)
        ST_IDLE: begin
          counter     <= '0;
          shadow_full <= 1'b0;
          if (transfer && i_enable) begin
            active         <= i_sample;
            state          <= ST_RUN;
            o_period_start <= 1'b1;
          end
        end

        ST_RUN: begin
          if (tick) counter <= counter + 1'b1;
          if (boundary) begin
            o_period_start <= 1'b1;
            if (shadow_full) begin
              active      <= shadow;
              shadow_full <= 1'b0;
            end else if (transfer) begin
              active <= i_sample;
            end else begin
              o_underrun <= 1'b1;
            end
          end else if (transfer) begin
            shadow      <= i_sample;
            shadow_full <= 1'b1;
          end
          // Stop request wins over any shadow update made this cycle.
          if (!i_enable) begin
            state       <= ST_DRAIN;
            shadow_full <= 1'b0;
          end
        end

        ST_DRAIN: begin
          if (tick) counter <= counter + 1'b1;
          if (boundary) state <= ST_IDLE;
        end

        default: begin
          state       <= ST_IDLE;
          counter     <= '0;
          shadow_full <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pwm_output_stage.md
PWM_OUTPUT_STAGE -- requirements
Module: pwm_output_stage

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, meaning clocks per PWM counter tick (legal 1..65535).
REQ-002 SHALL have parameter WIDTH, default 9, meaning sample and counter width in bits.
REQ-003 SHALL have port i_clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_enable  input  1  run request; low requests a stop at the next period boundary.
REQ-006 SHALL have port i_sample  input  WIDTH  duty-cycle compare value from a channel generator.
REQ-007 SHALL have port i_sample_valid  input  1  i_sample is valid this cycle.
REQ-008 SHALL have port o_sample_ready  output  1  block accepts i_sample this cycle.
REQ-009 SHALL have port o_pwm  output  1  registered PWM pin drive.
REQ-010 SHALL have port o_period_start  output  1  one-cycle pulse when the counter restarts at 0.
REQ-011 SHALL have port o_underrun  output  1  one-cycle pulse at a boundary with no new sample pending.

Function
REQ-012 SHALL generate a tick every PRESCALE clocks from a free-running prescaler, cleared to 0 in IDLE.
REQ-013 SHALL advance a WIDTH-bit period counter by 1 per tick in RUN/DRAIN, wrapping 2^WIDTH-1 -> 0 (period = 2^WIDTH ticks).
REQ-014 SHALL register o_pwm = (state != IDLE) && (counter < active); one clock latency from counter; active=0 gives constant low; active=2^WIDTH-1 gives high for all but one tick.
REQ-015 SHALL transfer a sample on i_sample_valid && o_sample_ready; o_sample_ready = 1 in IDLE, = !shadow_full in RUN, = 0 in DRAIN.
REQ-016 SHALL in IDLE, on a transfer with i_enable high, load active directly, set counter 0, enter RUN, and pulse o_period_start the next cycle.
REQ-017 SHALL in RUN, on a transfer not at a boundary, store the sample in a one-entry shadow register.
REQ-018 SHALL define boundary as a tick with counter = 2^WIDTH-1; at a boundary in RUN: shadow full -> active <= shadow, shadow emptied; shadow empty with simultaneous transfer -> active <= i_sample directly, no underrun; otherwise active held and o_underrun pulses.
REQ-019 SHALL pulse o_period_start for one clock at every boundary in RUN (counter becomes 0).
REQ-020 SHALL move RUN -> DRAIN when i_enable is low; shadow contents discarded on entry.
REQ-021 SHALL move DRAIN -> IDLE at the next boundary, with no o_period_start or o_underrun pulse for that boundary; if i_enable returns high in DRAIN, the block still completes DRAIN -> IDLE.
REQ-022 SHALL ignore samples in IDLE while i_enable is low (ready high, data dropped).
REQ-023 SHALL keep states exactly IDLE, RUN, DRAIN; unreachable encodings return to IDLE.

Reset
REQ-024 SHALL on i_rst_n low, immediately and asynchronously force IDLE, counter 0, prescaler 0, active 0, shadow empty, o_pwm 0, o_period_start 0, o_underrun 0.
REQ-025 SHALL after reset release, drive o_sample_ready 1 and remain idle until the first enabled transfer.
REQ-026 SHALL, when reset is asserted mid-period, drop o_pwm low without completing the period.

Structure
REQ-027 SHALL take WIDTH default and the state encoding from the shared audio package pwm_pkg.
REQ-028 SHALL implement the tick generator as sub-module pwm_prescaler (i_clk, i_rst_n, i_clear, o_tick).
REQ-029 SHALL contain no combinational path from i_sample to o_pwm.

Verification
REQ-030 SHALL test: WIDTH=9, PRESCALE=1, enable, one sample 128 -> o_period_start 1 cycle after accept, o_pwm high exactly 128 of each 512 clocks, o_underrun every 512 clocks thereafter.
REQ-031 SHALL test: samples 0 and 511 in consecutive periods -> first period o_pwm low throughout; second high 511 clocks, low 1.
REQ-032 SHALL test: PRESCALE=4, sample 10 -> o_pwm high 40 clocks per 2048-clock period.
REQ-033 SHALL test: shadow full (ready low), sample 300 offered at boundary with shadow empty -> bypass load, o_pwm high 300 ticks next period, no underrun.
REQ-034 SHALL test: drop i_enable at counter 100 -> period completes, IDLE at boundary, o_pwm 0, no pulses, ready 1.
REQ-035 SHALL test: assert i_rst_n low at counter 50 with o_pwm high -> o_pwm 0 and ready 1 immediately, no pulses after release.
